// File: rtl/load_store_unit_pkg.sv
// Shared definitions for the load/store unit: width codes, FSM states and
// the byte-enable / store-replication / load-extension helpers.
package lsu_pkg;

    // Width codes driven by the main decoder on LSen
    localparam logic [2:0] LSEN_B  = 3'b000;
    localparam logic [2:0] LSEN_H  = 3'b001;
    localparam logic [2:0] LSEN_W  = 3'b010;
    localparam logic [2:0] LSEN_BU = 3'b011;
    localparam logic [2:0] LSEN_HU = 3'b100;

    typedef enum logic [1:0] {IDLE, WAIT, DONE} lsu_state_e;

    typedef enum logic [1:0] {SzByte, SzHalf, SzWord} lsu_size_e;

    // Codes 101-111 fall through to word
    function automatic lsu_size_e lsu_size(input logic [2:0] lsen);
        case (lsen)
            LSEN_B, LSEN_BU: return SzByte;
            LSEN_H, LSEN_HU: return SzHalf;
            default:         return SzWord;
        endcase
    endfunction

    function automatic logic lsu_misaligned(input logic [2:0] lsen, input logic [1:0] off);
        case (lsu_size(lsen))
            SzByte:  return 1'b0;
            SzHalf:  return off[0];
            default: return off != 2'b00;
        endcase
    endfunction

    function automatic logic [3:0] lsu_be(input logic [2:0] lsen, input logic [1:0] off);
        case (lsu_size(lsen))
            SzByte:  return 4'b0001 << off;
            SzHalf:  return off[1] ? 4'b1100 : 4'b0011;
            default: return 4'b1111;
        endcase
    endfunction

    // Replicate the store operand across every lane it may land in
    function automatic logic [31:0] lsu_store_data(input logic [2:0] lsen,
                                                   input logic [31:0] wdata);
        case (lsu_size(lsen))
            SzByte:  return {4{wdata[7:0]}};
            SzHalf:  return {2{wdata[15:0]}};
            default: return wdata;
        endcase
    endfunction

    function automatic logic [31:0] lsu_load_ext(input logic [2:0] lsen, input logic [1:0] off,
                                                 input logic [31:0] rdata);
        logic [7:0]  b;
        logic [15:0] h;
        b = rdata[{off, 3'b000} +: 8];
        h = rdata[{off[1], 4'b0000} +: 16];
        case (lsen)
            LSEN_B:  return {{24{b[7]}}, b};
            LSEN_H:  return {{16{h[15]}}, h};
            LSEN_BU: return {24'b0, b};
            LSEN_HU: return {16'b0, h};
            default: return rdata;
        endcase
    endfunction

endpackage

// File: rtl/load_store_unit_if.sv
// Data-memory req/ack port. master = load/store unit, slave = memory.
interface load_store_unit_if #(
    parameter int unsigned XLEN = 32
) ();
    logic            dmem_req;
    logic            dmem_we;
    logic [XLEN-1:0] dmem_addr;
    logic [3:0]      dmem_be;
    logic [XLEN-1:0] dmem_wdata;
    logic [XLEN-1:0] dmem_rdata;
    logic            dmem_ack;

    modport master (
        output dmem_req, dmem_we, dmem_addr, dmem_be, dmem_wdata,
        input  dmem_rdata, dmem_ack
    );

    modport slave (
        input  dmem_req, dmem_we, dmem_addr, dmem_be, dmem_wdata,
        output dmem_rdata, dmem_ack
    );
endinterface

// File: rtl/load_store_unit_align.sv
// Lane logic: byte enables and store replication for the incoming op, and
// extension of returned read data using the offset latched at issue.
module lsu_align
    import lsu_pkg::*;
#(
    parameter int unsigned XLEN = 32
) (
    input  logic [2:0]      i_lsen,
    input  logic [1:0]      i_off,
    input  logic [XLEN-1:0] i_wdata,
    input  logic [2:0]      i_ld_lsen,
    input  logic [1:0]      i_ld_off,
    input  logic [XLEN-1:0] i_rdata,
    output logic [3:0]      o_be,
    output logic [XLEN-1:0] o_wdata,
    output logic [XLEN-1:0] o_load_ext
);

    // Pure lane steering, no state
    always_comb begin
        o_be       = lsu_be(i_lsen, i_off);
        o_wdata    = lsu_store_data(i_lsen, i_wdata);
        o_load_ext = lsu_load_ext(i_ld_lsen, i_ld_off, i_rdata);
    end

endmodule

// File: rtl/load_store_unit.sv
// Load/store unit: issues one registered data-memory request per load or
// store, stalls the core until ack or timeout, and returns extended loads.
module load_store_unit
    import lsu_pkg::*;
#(
    parameter int unsigned XLEN    = 32,
    parameter int unsigned TIMEOUT = 255
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            i_mem_write,
    input  logic            i_mem_read,
    input  logic [2:0]      i_lsen,
    input  logic [XLEN-1:0] i_addr,
    input  logic [XLEN-1:0] i_wdata,
    output logic            o_stall,
    output logic [XLEN-1:0] o_load_data,
    output logic            o_load_valid,
    output logic            o_misalign_err,
    output logic            o_bus_err,
    load_store_unit_if.master dmem
);

    localparam logic [15:0] CntLast = 16'(TIMEOUT - 1);

    lsu_state_e      r_state, w_state_d;
    logic [15:0]     r_cnt;
    logic            r_we, r_timed_out, r_misalign;
    logic [XLEN-1:0] r_addr, r_wdata, r_load_data;
    logic [3:0]      r_be;
    logic [2:0]      r_lsen;
    logic [1:0]      r_off;

    logic            w_op_valid, w_misaligned, w_start, w_ack_done, w_timeout;
    logic [3:0]      w_be;
    logic [XLEN-1:0] w_wdata_rep, w_load_ext;

    assign w_op_valid   = i_mem_read | i_mem_write;
    assign w_misaligned = lsu_misaligned(i_lsen, i_addr[1:0]);

    lsu_align #(.XLEN(XLEN)) u_align (
        .i_lsen     (i_lsen),
        .i_off      (i_addr[1:0]),
        .i_wdata    (i_wdata),
        .i_ld_lsen  (r_lsen),
        .i_ld_off   (r_off),
        .i_rdata    (dmem.dmem_rdata),
        .o_be       (w_be),
        .o_wdata    (w_wdata_rep),
        .o_load_ext (w_load_ext)
    );

    // Next-state decode; ack wins over a timeout in the same cycle
    always_comb begin
        w_state_d  = r_state;
        w_start    = 1'b0;
        w_ack_done = 1'b0;
        w_timeout  = 1'b0;
        case (r_state)
            IDLE: begin
                if (w_op_valid && !w_misaligned) begin
                    w_start   = 1'b1;
                    w_state_d = WAIT;
                end
            end
            WAIT: begin
                if (dmem.dmem_ack) begin
                    w_ack_done = 1'b1;
                    w_state_d  = DONE;
                end else if (r_cnt == CntLast) begin
                    w_timeout = 1'b1;
                    w_state_d = DONE;
                end
            end
            DONE:    w_state_d = IDLE;
            default: w_state_d = IDLE;
        endcase
    end

    // State register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_d;
        end
    end

    // Request fields, wait counter, result and error flags
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_cnt       <= '0;
            r_we        <= 1'b0;
            r_timed_out <= 1'b0;
            r_misalign  <= 1'b0;
            r_addr      <= '0;
            r_wdata     <= '0;
            r_be        <= '0;
            r_lsen      <= '0;
            r_off       <= '0;
            r_load_data <= '0;
        end else begin
            r_misalign <= (r_state == IDLE) && w_op_valid && w_misaligned;
            if (w_start) begin
                r_we        <= i_mem_write;
                r_addr      <= {i_addr[XLEN-1:2], 2'b00};
                r_be        <= w_be;
                r_wdata     <= w_wdata_rep;
                r_lsen      <= i_lsen;
                r_off       <= i_addr[1:0];
                r_timed_out <= 1'b0;
            end else if (w_timeout) begin
                r_timed_out <= 1'b1;
            end
            r_cnt <= (r_state == WAIT) ? r_cnt + 16'd1 : '0;
            if (w_ack_done && !r_we) begin
                r_load_data <= w_load_ext;
            end else if (w_timeout && !r_we) begin
                r_load_data <= '0;
            end
        end
    end

    // Outputs; stall is masked during reset so the core sees zeros at once
    always_comb begin
        o_stall         = !rst && (w_start || (r_state == WAIT));
        o_load_data     = r_load_data;
        o_load_valid    = (r_state == DONE) && !r_we && !r_timed_out;
        o_misalign_err  = r_misalign;
        o_bus_err       = (r_state == DONE) && r_timed_out;
        dmem.dmem_req   = (r_state == WAIT);
        dmem.dmem_we    = r_we;
        dmem.dmem_addr  = r_addr;
        dmem.dmem_be    = r_be;
        dmem.dmem_wdata = r_wdata;
    end

endmodule

// File: tb/tb_load_store_unit.sv
// Bench for load_store_unit: directed cases followed by random loads/stores,
// checked against an arithmetic model of lanes, extension and latency.
module tb_load_store_unit;

    localparam int TO = 4;

    logic        clk = 1'b0;
    logic        rst;
    logic        mem_write, mem_read;
    logic [2:0]  lsen;
    logic [31:0] addr, wdata;
    logic        stall, load_valid, misalign_err, bus_err;
    logic [31:0] load_data;
    logic [31:0] exp_ld;
    int          n_tests = 0;
    int          n_fail  = 0;

    load_store_unit_if #(.XLEN(32)) bus ();

    load_store_unit #(.XLEN(32), .TIMEOUT(TO)) dut (
        .clk            (clk),
        .rst            (rst),
        .i_mem_write    (mem_write),
        .i_mem_read     (mem_read),
        .i_lsen         (lsen),
        .i_addr         (addr),
        .i_wdata        (wdata),
        .o_stall        (stall),
        .o_load_data    (load_data),
        .o_load_valid   (load_valid),
        .o_misalign_err (misalign_err),
        .o_bus_err      (bus_err),
        .dmem           (bus)
    );

    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // ---- reference model ----
    function automatic int m_size(input logic [2:0] l);
        if (l == 3'd0 || l == 3'd3) return 1;
        if (l == 3'd1 || l == 3'd4) return 2;
        return 4;
    endfunction

    function automatic logic [3:0] m_be(input logic [2:0] l, input logic [31:0] a);
        int s = m_size(l);
        int off = int'(a % 4);
        return 4'(((1 << s) - 1) << off);
    endfunction

    function automatic logic [31:0] m_wdata(input logic [2:0] l, input logic [31:0] wd);
        logic [31:0] r;
        int s = m_size(l);
        for (int i = 0; i < 4; i++) r[8*i +: 8] = wd[8*(i % s) +: 8];
        return r;
    endfunction

    function automatic logic [31:0] m_load(input logic [2:0] l, input logic [31:0] a,
                                           input logic [31:0] rd);
        int s = m_size(l);
        logic [31:0] v;
        logic [31:0] mask;
        if (s == 4) return rd;
        mask = (32'd1 << (8 * s)) - 32'd1;
        v = (rd >> (8 * (a % 4))) & mask;
        if ((l == 3'd0 || l == 3'd1) && v[8*s-1]) v = v | ~mask;
        return v;
    endfunction

    task automatic idle_inputs();
        mem_write = 1'b0;
        mem_read  = 1'b0;
        lsen      = 3'd0;
        addr      = '0;
        wdata     = '0;
    endtask

    // Runs one op starting just after a rising edge with the unit idle.
    // ack_at: WAIT cycle index in which ack is given; <0 means never.
    task automatic run_op(input logic st, input logic rd, input logic [2:0] l,
                          input logic [31:0] a, input logic [31:0] wd,
                          input logic [31:0] rdat, input int ack_at);
        logic is_store = st;
        int   s = m_size(l);
        logic mis = (a % s) != 0;
        logic timed_out;
        mem_write = st;
        mem_read  = rd;
        lsen      = l;
        addr      = a;
        wdata     = wd;
        bus.dmem_ack = 1'b0;
        @(negedge clk);
        check("issue_stall", stall, !mis);
        check("issue_req", bus.dmem_req, 1'b0);
        if (mis) begin
            @(posedge clk); #1;
            idle_inputs();
            @(negedge clk);
            check("mis_err", misalign_err, 1'b1);
            check("mis_stall", stall, 1'b0);
            check("mis_req", bus.dmem_req, 1'b0);
            @(posedge clk); #1;
            @(negedge clk);
            check("mis_err_clr", misalign_err, 1'b0);
            check("mis_req2", bus.dmem_req, 1'b0);
            @(posedge clk); #1;
            return;
        end
        @(posedge clk); #1;
        timed_out = 1'b1;
        for (int k = 0; k < TO; k++) begin
            if (k == ack_at) begin
                bus.dmem_ack   = 1'b1;
                bus.dmem_rdata = rdat;
            end
            @(negedge clk);
            check("wait_req", bus.dmem_req, 1'b1);
            check("wait_stall", stall, 1'b1);
            check("wait_we", bus.dmem_we, is_store);
            check("wait_addr", bus.dmem_addr, {a[31:2], 2'b00});
            check("wait_be", bus.dmem_be, m_be(l, a));
            check("wait_wdata", bus.dmem_wdata, m_wdata(l, wd));
            check("wait_lv", load_valid, 1'b0);
            @(posedge clk); #1;
            bus.dmem_ack   = 1'b0;
            bus.dmem_rdata = $urandom;
            if (k == ack_at) begin
                timed_out = 1'b0;
                break;
            end
        end
        if (!is_store) exp_ld = timed_out ? 32'd0 : m_load(l, a, rdat);
        @(negedge clk);
        check("done_stall", stall, 1'b0);
        check("done_req", bus.dmem_req, 1'b0);
        check("done_lv", load_valid, !is_store && !timed_out);
        check("done_buserr", bus_err, timed_out);
        check("done_ldata", load_data, exp_ld);
        @(posedge clk); #1;
        idle_inputs();
        @(negedge clk);
        check("post_lv", load_valid, 1'b0);
        check("post_buserr", bus_err, 1'b0);
        check("post_req", bus.dmem_req, 1'b0);
        check("post_ldata", load_data, exp_ld);
        @(posedge clk); #1;
    endtask

    initial begin
        logic st, rd;
        logic [2:0] l;
        rst = 1'b1;
        exp_ld = '0;
        idle_inputs();
        bus.dmem_ack   = 1'b0;
        bus.dmem_rdata = '0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("rst_stall", stall, 1'b0);
        check("rst_req", bus.dmem_req, 1'b0);
        check("rst_be", bus.dmem_be, 4'b0);
        check("rst_ldata", load_data, 32'd0);
        check("rst_lv", load_valid, 1'b0);
        check("rst_errs", {misalign_err, bus_err}, 2'b00);
        @(posedge clk); #1;
        rst = 1'b0;
        @(posedge clk); #1;

        // LB 0x103, ack in first WAIT cycle
        run_op(1'b0, 1'b1, 3'd0, 32'h103, 32'h0, 32'h80FF_1234, 0);
        check("lb_result", exp_ld, 32'hFFFF_FF80);
        // LHU 0x202, ack in third WAIT cycle
        run_op(1'b0, 1'b1, 3'd4, 32'h202, 32'h0, 32'h8001_0000, 2);
        check("lhu_result", exp_ld, 32'h0000_8001);
        // SB 0x101
        run_op(1'b1, 1'b0, 3'd0, 32'h101, 32'hAABB_CCDD, 32'h0, 0);
        // LW misaligned
        run_op(1'b0, 1'b1, 3'd2, 32'h102, 32'h0, 32'h0, 0);
        // SW with no ack: timeout
        run_op(1'b1, 1'b0, 3'd2, 32'h400, 32'h1234_5678, 32'h0, -1);
        // Load and store both high is a store
        run_op(1'b1, 1'b1, 3'd1, 32'h0C2, 32'h0000_BEEF, 32'hFFFF_FFFF, 1);

        // Reset in the middle of WAIT
        mem_read = 1'b1;
        lsen     = 3'd2;
        addr     = 32'h40;
        @(posedge clk); #1;
        @(posedge clk); #1;
        rst = 1'b1;
        idle_inputs();
        exp_ld = '0;
        #1;
        check("mrst_req", bus.dmem_req, 1'b0);
        check("mrst_stall", stall, 1'b0);
        check("mrst_addr", bus.dmem_addr, 32'd0);
        check("mrst_be", bus.dmem_be, 4'd0);
        @(posedge clk); #1;
        rst = 1'b0;
        bus.dmem_ack   = 1'b1;
        bus.dmem_rdata = 32'hDEAD_BEEF;
        @(negedge clk);
        check("late_ack_req", bus.dmem_req, 1'b0);
        check("late_ack_stall", stall, 1'b0);
        @(posedge clk); #1;
        bus.dmem_ack = 1'b0;
        @(negedge clk);
        check("late_ack_lv", load_valid, 1'b0);
        check("late_ack_ldata", load_data, 32'd0);
        @(posedge clk); #1;
        run_op(1'b0, 1'b1, 3'd2, 32'h44, 32'h0, 32'hCAFE_F00D, 0);

        // Random mix
        for (int n = 0; n < 60; n++) begin
            st = 1'($urandom_range(0, 1));
            rd = st ? 1'($urandom_range(0, 1)) : 1'b1;
            l  = 3'($urandom_range(0, 7));
            run_op(st, rd, l, $urandom, $urandom, $urandom, int'($urandom_range(0, TO - 1)));
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/load_store_unit.md
Name: load_store_unit

Overview:
- Data-memory stage directly downstream of the main decoder. Consumes its memory-write strobe, load-select strobe and 3-bit LSen width code, plus the ALU effective address and rs2 store data.
- Issues one registered request per load/store on a req/ack data-memory port, with byte enables and lane-replicated write data.
- Sign- or zero-extends load data and stalls the core until the access completes.
- Flags misaligned accesses and bus timeouts.

Parameters:
- XLEN, 32, data/address width (only 32 supported)
- TIMEOUT, 255, maximum cycles in WAIT before a bus error is declared (1..2^16-1)

Ports:
- clk  in  1  system clock
- rst  in  1  reset, asynchronous, active-high
- mem_write  in  1  store strobe from decoder (MemWrite)
- mem_read  in  1  load strobe (decoder MemtoReg==2'b01)
- lsen  in  3  width code: 000 B/SB, 001 H/SH, 010 W/SW, 011 BU, 100 HU; 101-111 treated as 010
- addr  in  XLEN  effective address from ALU
- wdata  in  XLEN  store data (rs2)
- stall  out  1  hold PC/pipeline while asserted
- load_data  out  XLEN  extended load result, valid when load_valid=1
- load_valid  out  1  one-cycle pulse with load result
- misalign_err  out  1  one-cycle pulse: misaligned access dropped
- bus_err  out  1  one-cycle pulse: timeout
- dmem_req  out  1  request, held until ack
- dmem_we  out  1  1=write
- dmem_addr  out  XLEN  word address ({addr[31:2],2'b00})
- dmem_be  out  4  byte enables
- dmem_wdata  out  XLEN  lane-replicated store data
- dmem_rdata  in  XLEN  read data, sampled on ack
- dmem_ack  in  1  completion; ignored outside WAIT

Behaviour:
- States: IDLE, WAIT, DONE. Reset (async) forces IDLE immediately.
- Reset values: all outputs 0; wait counter 0.
- op_valid = mem_read | mem_write. If both are high, treat as a store.
- Misaligned: H/HU/SH with addr[0]=1; W/SW with addr[1:0]!=0.
- IDLE, op_valid, aligned:
  - stall=1 combinationally.
  - Latch we, dmem_addr, dmem_be, dmem_wdata, lsen, addr[1:0].
  - Next state WAIT.
- IDLE, op_valid, misaligned:
  - Registered misalign_err pulse next cycle; no request; stall=0; remain IDLE.
- WAIT:
  - dmem_req=1, stall=1; registered request fields stable; counter increments each cycle.
  - On ack: capture the extended load (loads only) into load_data; next state DONE.
  - On counter reaching TIMEOUT-1 without ack: drop req, bus_err pulse in DONE, load_data=0.
- DONE:
  - stall=0, dmem_req=0; load_valid=1 for loads only; bus_err=1 if timed out.
  - Unconditionally return to IDLE. The core advances on this edge, so the same instruction is never reissued.
- Latency: ack in the first WAIT cycle gives stall high for 2 cycles, with the result in cycle 3.
- Byte enables:
  - B/SB: 4'b0001<<addr[1:0]
  - H/SH: addr[1] ? 4'b1100 : 4'b0011
  - W: 4'b1111
  - Loads also drive dmem_be.
- Store data: SB replicates wdata[7:0] ×4; SH replicates wdata[15:0] ×2; SW passes through.
- Load extraction from the latched offset:
  - Byte = rdata[8*off+:8]; half = rdata[16*off[1]+:16].
  - B/H sign-extend, BU/HU zero-extend, W passes through.
- load_data holds its value until the next load completes.

Decomposition:
- Package lsu_pkg: LSEN_B/H/W/BU/HU localparams (shared with decoder), state enum {IDLE,WAIT,DONE}, be/extension functions.
- One sub-module, lsu_align: combinational be/wdata replication and load extension. The top holds the FSM, registers and counter.

Test Plan:
- LB addr=0x103, rdata=0x80FF_1234, ack in 1st WAIT → be=1000, stall 2 cycles, load_data=0xFFFFFF80, load_valid 1 cycle.
- LHU addr=0x202, rdata=0x8001_0000, ack after 3 WAIT cycles → be=1100, stall 4 cycles, load_data=0x00008001.
- SB addr=0x101, wdata=0xAABBCCDD → we=1, be=0010, dmem_wdata=0xDDDDDDDD, dmem_addr=0x100, no load_valid.
- LW addr=0x102 → misalign_err pulse next cycle, dmem_req never high, stall=0.
- TIMEOUT=4, SW with no ack → req high 4 cycles then low, bus_err pulse, stall releases, state IDLE.
- rst asserted mid-WAIT → dmem_req, stall, outputs 0 same cycle; a later ack is ignored; next op proceeds normally.
